mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Single-clock run controller for the pipelined MIPS32 core. It streams a program image from a host port into instruction memory and issues a one-cycle core init that clears PC, HALTED and TAKEN_BRANCH. It then lets the core run until HALTED or a watchdog expires, and dumps a configurable register window back to the host over a valid/ready stream. It sits between the host/bench and the core's Mem/Reg arrays, replacing hierarchical pokes with a synthesizable sequence.

## Interface
- ADDR_W, 10, instruction memory address width
- MEM_WORDS, 1024, memory depth in words (≤ 2^ADDR_W)
- DUMP_REGS, 6, registers dumped (R0..R[DUMP_REGS-1]), 1..32
- TIMEOUT_CYC, 1000, max RUN cycles before watchdog fires (1..65535)

- clk1  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- host_wr_valid  in  1  program word valid
- host_wr_ready  out  1  program word accepted when valid&ready
- host_wr_data  in  32  instruction word
- host_wr_last  in  1  final word of image
- mem_we  out  1  instruction memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  write data
- core_init  out  1  one-cycle pulse: core clears PC, HALTED, TAKEN_BRANCH
- core_run  out  1  core advance enable
- core_halted  in  1  core HALTED flag
- reg_rd_addr  out  5  register file read address (combinational read)
- reg_rd_data  in  32  register file read data
- dump_valid  out  1  dump word valid
- dump_ready  in  1  host accepts dump word
- dump_data  out  32  register value
- dump_idx  out  5  register index of dump_data
- dump_last  out  1  marks final dump word
- busy  out  1  high in any state except IDLE
- timeout  out  1  sticky watchdog flag
- run_cycles  out  16  RUN-cycle count of last run, saturating

## Operation
- States: IDLE, LOAD, INIT, RUN, DUMP_RD, DUMP_OUT, DONE.
- IDLE: host_wr_ready=1. First accepted word goes to address 0, state → LOAD (or INIT if last). Accepting a word clears timeout and run_cycles.
- LOAD: host_wr_ready=1; each accepted word writes mem_addr = word index (mem_we same cycle as handshake, combinational from it). Address increments per accepted word; gaps in valid are allowed.
- Overflow: word at address MEM_WORDS-1 is treated as last regardless of host_wr_last.
- Last accepted → INIT: core_init=1 for exactly one cycle, core_run=0.
- RUN: core_run=1; run_cycles increments each cycle (1 in first RUN cycle). core_halted=1 → DUMP_RD. Else if run_cycles reaches TIMEOUT_CYC → timeout=1, DUMP_RD. Both in same cycle: halt wins, timeout stays 0.
- DUMP_RD: reg_rd_addr=idx; reg_rd_data captured into dump_data; → DUMP_OUT.
- DUMP_OUT: dump_valid=1, data/idx/last stable until dump_ready. On handshake: idx=DUMP_REGS-1 → DONE, else idx+1 → DUMP_RD.
- DONE: one cycle, busy=0 next cycle, → IDLE. Memory contents are retained; a new load overwrites from address 0.
- host_wr_ready=0 outside IDLE/LOAD; host words offered then are ignored.

## Timing
- Reset (async assert, sync to clk1 on release): state IDLE, all outputs 0 except host_wr_ready=1; timeout=0, run_cycles=0, idx=0.
- Load: 1 word/cycle at full rate; N words take N cycles; INIT the cycle after last.
- RUN begins cycle after INIT; core_halted is ignored during INIT.
- Halt-to-first-dump_valid: 2 cycles (DUMP_RD, DUMP_OUT). Minimum 2 cycles per dump word.
- Reset mid-operation: immediate return to IDLE, core_run/core_init/mem_we/dump_valid drop asynchronously; partial load is abandoned.

## Test plan
- Addition program (ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; OR×2; ADD R4,R1,R2; OR; ADD R5,R4,R3; HLT, 9 words) on core model → dump R0..R5 = 0,10,20,25,30,55, dump_last on idx 5, timeout=0.
- Dump backpressure: dump_ready low 5 cycles at idx 2 → dump_data/idx held constant, no word skipped or duplicated.
- Watchdog: TIMEOUT_CYC=50, core never halts → timeout=1, run_cycles=50, dump still completes; core_halted and timeout coincide → timeout=0.
- Load gaps/overflow: MEM_WORDS=8, 10 words with valid toggling, last never asserted → writes addresses 0..7 only, INIT after 8th word, words 9–10 not accepted.
- Reset mid-RUN: rst_n low for 1 cycle → core_run=0 immediately, busy=0, host_wr_ready=1; subsequent load runs normally.
- Back-to-back runs: second image loaded after DONE clears timeout/run_cycles on first accepted word and produces correct dump.

Source files
------------

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS32 core: load image, init pulse, watchdog-bounded run, register dump.
// Load takes 1 word/cycle (ready only in IDLE/LOAD); dump takes >=2 cycles/word and holds the word while dump_ready=0.
module mips_run_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int MEM_WORDS   = 1024,
    parameter int DUMP_REGS   = 6,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [31:0]       host_wr_data,
    input  logic              host_wr_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_init,
    output logic              core_run,
    input  logic              core_halted,
    output logic [4:0]        reg_rd_addr,
    input  logic [31:0]       reg_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic [4:0]        dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              timeout,
    output logic [15:0]       run_cycles
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [4:0]        LAST_IDX  = 5'(DUMP_REGS - 1);
    localparam logic [15:0]       WD_LIMIT  = 16'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_INIT, S_RUN, S_DUMP_RD, S_DUMP_OUT, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic [4:0]        idx, idx_nxt;
    logic [31:0]       dump_dat, dump_dat_nxt;
    logic              timeout_nxt;
    logic [15:0]       run_cycles_nxt;
    logic [15:0]       run_inc;

    assign dump_data = dump_dat;
    assign dump_idx  = idx;

    always_comb begin
        state_nxt      = state;
        wr_addr_nxt    = wr_addr;
        idx_nxt        = idx;
        dump_dat_nxt   = dump_dat;
        timeout_nxt    = timeout;
        run_cycles_nxt = run_cycles;
        host_wr_ready  = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        core_init      = 1'b0;
        core_run       = 1'b0;
        reg_rd_addr    = idx;
        dump_valid     = 1'b0;
        dump_last      = 1'b0;
        busy           = (state != S_IDLE);
        run_inc        = (run_cycles == 16'hFFFF) ? run_cycles : run_cycles + 16'd1;

        case (state)
            S_IDLE, S_LOAD: begin
                host_wr_ready = 1'b1;
                // The first word of an image always lands at address 0.
                mem_addr      = (state == S_IDLE) ? '0 : wr_addr;
                if (host_wr_valid) begin
                    mem_we      = 1'b1;
                    mem_wdata   = host_wr_data;
                    wr_addr_nxt = mem_addr + 1'b1;
                    if (state == S_IDLE) begin
                        timeout_nxt    = 1'b0;
                        run_cycles_nxt = '0;
                    end
                    if (host_wr_last || (mem_addr == LAST_ADDR)) begin
                        state_nxt = S_INIT;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_INIT: begin
                core_init = 1'b1;
                idx_nxt   = '0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                core_run       = 1'b1;
                run_cycles_nxt = run_inc;
                // A halt seen on the watchdog's last cycle is a clean finish.
                if (core_halted) begin
                    state_nxt = S_DUMP_RD;
                end else if (run_inc == WD_LIMIT) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DUMP_RD;
                end
            end
            S_DUMP_RD: begin
                dump_dat_nxt = reg_rd_data;
                state_nxt    = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                dump_valid = 1'b1;
                dump_last  = (idx == LAST_IDX);
                if (dump_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + 5'd1;
                        state_nxt = S_DUMP_RD;
                    end
                end
            end
            S_DONE: begin
                idx_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_addr    <= '0;
            idx        <= '0;
            dump_dat   <= '0;
            timeout    <= 1'b0;
            run_cycles <= '0;
        end else begin
            state      <= state_nxt;
            wr_addr    <= wr_addr_nxt;
            idx        <= idx_nxt;
            dump_dat   <= dump_dat_nxt;
            timeout    <= timeout_nxt;
            run_cycles <= run_cycles_nxt;
        end
    end
endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a one-instruction-per-cycle core stub and a second small-memory instance.
module tb_mips_run_ctrl;
    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n;
    logic        host_wr_valid, host_wr_ready, host_wr_last;
    logic [31:0] host_wr_data;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_init, core_run, core_halted;
    logic [4:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        dump_valid, dump_ready, dump_last;
    logic [31:0] dump_data;
    logic [4:0]  dump_idx;
    logic        busy, timeout;
    logic [15:0] run_cycles;

    logic        ovf_valid, ovf_ready, ovf_we, ovf_init, ovf_run;
    logic [2:0]  ovf_addr;
    logic [31:0] ovf_wdata, ovf_ddata;
    logic [4:0]  ovf_rd_addr, ovf_didx;
    logic        ovf_dvalid, ovf_dlast, ovf_busy, ovf_timeout;
    logic [15:0] ovf_rc;

    mips_run_ctrl #(.ADDR_W(10), .MEM_WORDS(1024), .DUMP_REGS(6), .TIMEOUT_CYC(50)) dut (
        .clk1(clk1), .rst_n(rst_n),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_data(host_wr_data), .host_wr_last(host_wr_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_init(core_init), .core_run(core_run), .core_halted(core_halted),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last),
        .busy(busy), .timeout(timeout), .run_cycles(run_cycles)
    );

    mips_run_ctrl #(.ADDR_W(3), .MEM_WORDS(8), .DUMP_REGS(6), .TIMEOUT_CYC(50)) dut_ovf (
        .clk1(clk1), .rst_n(rst_n),
        .host_wr_valid(ovf_valid), .host_wr_ready(ovf_ready),
        .host_wr_data(host_wr_data), .host_wr_last(host_wr_last),
        .mem_we(ovf_we), .mem_addr(ovf_addr), .mem_wdata(ovf_wdata),
        .core_init(ovf_init), .core_run(ovf_run), .core_halted(1'b1),
        .reg_rd_addr(ovf_rd_addr), .reg_rd_data(32'h0),
        .dump_valid(ovf_dvalid), .dump_ready(1'b1), .dump_data(ovf_ddata),
        .dump_idx(ovf_didx), .dump_last(ovf_dlast),
        .busy(ovf_busy), .timeout(ovf_timeout), .run_cycles(ovf_rc)
    );

    int checks = 0;
    int errors = 0;

    // Core stub: one instruction per core_run cycle (ADDI, ADD, OR, HLT).
    logic [31:0] imem [1024];
    logic [31:0] regs [32];
    logic [9:0]  pc;
    logic        halted;
    logic [31:0] ir;
    logic        block_halt = 1'b0;
    int          inject_at = 0;
    int          run_k = 0;

    assign ir          = imem[pc];
    assign reg_rd_data = regs[reg_rd_addr];
    assign core_halted = (halted && !block_halt) || (inject_at != 0 && core_run && run_k == inject_at);

    always @(negedge clk1) run_k <= core_run ? run_k + 1 : 0;

    always @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0; halted <= 1'b0;
        end else if (core_init) begin
            pc <= '0; halted <= 1'b0;
        end else if (core_run && !halted) begin
            pc <= pc + 10'd1;
            case (ir[31:26])
                6'b001000: if (ir[20:16] != 5'd0)
                    regs[ir[20:16]] <= regs[ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
                6'b000000: if (ir[15:11] != 5'd0) begin
                    if (ir[5:0] == 6'b100000) regs[ir[15:11]] <= regs[ir[25:21]] + regs[ir[20:16]];
                    else if (ir[5:0] == 6'b100101) regs[ir[15:11]] <= regs[ir[25:21]] | regs[ir[20:16]];
                end
                6'b111111: halted <= 1'b1;
                default: ;
            endcase
        end
    end

    int          cyc = 0;
    int          wr_log[$];
    int          ovf_log[$];
    logic [31:0] ovf_mem [8];
    int          ovf_init_cnt = 0, ovf_init_cyc = 0, ovf_last_wr_cyc = 0;

    always @(posedge clk1) begin
        cyc <= cyc + 1;
        if (mem_we) begin
            imem[mem_addr] <= mem_wdata;
            wr_log.push_back(int'(mem_addr));
        end
        if (ovf_we) begin
            ovf_mem[ovf_addr] <= ovf_wdata;
            ovf_log.push_back(int'(ovf_addr));
            ovf_last_wr_cyc <= cyc;
        end
        if (ovf_init) begin
            ovf_init_cnt <= ovf_init_cnt + 1;
            ovf_init_cyc <= cyc;
        end
    end

    logic [31:0] prog [16];
    logic [31:0] got_data [6];
    logic [4:0]  got_idx [6];
    logic        got_last [6];
    logic [31:0] held_data [16];
    logic [4:0]  held_idx [16];
    int          ncol, nheld;

    task automatic set_add_prog();
        prog[0] = 32'h2001000A; prog[1] = 32'h20020014; prog[2] = 32'h20030019;
        prog[3] = 32'h00E73825; prog[4] = 32'h00E73825; prog[5] = 32'h00222020;
        prog[6] = 32'h00E73825; prog[7] = 32'h00832820; prog[8] = 32'hFC000000;
    endtask

    task automatic load_words(input int n, input bit gaps, input bit use_last, input bit to_ovf);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                @(negedge clk1);
                host_wr_valid = 1'b0; ovf_valid = 1'b0;
            end
            @(negedge clk1);
            if (to_ovf) ovf_valid = 1'b1; else host_wr_valid = 1'b1;
            host_wr_data = prog[i];
            host_wr_last = use_last && (i == n - 1);
        end
        @(negedge clk1);
        host_wr_valid = 1'b0; ovf_valid = 1'b0; host_wr_last = 1'b0;
    endtask

    // Accepts up to six dump words, stalling stall_cyc cycles on stall_idx; caller is at a negedge.
    task automatic collect(input int stall_idx, input int stall_cyc);
        int stalls = 0;
        ncol = 0; nheld = 0;
        for (int c = 0; c < 300 && ncol < 6; c++) begin
            if (c > 0) @(negedge clk1);
            if (dump_valid) begin
                if (dump_idx == stall_idx && stalls < stall_cyc) begin
                    dump_ready = 1'b0;
                    held_data[nheld] = dump_data; held_idx[nheld] = dump_idx;
                    nheld++; stalls++;
                end else begin
                    dump_ready = 1'b1;
                    got_data[ncol] = dump_data; got_idx[ncol] = dump_idx; got_last[ncol] = dump_last;
                    ncol++;
                end
            end else begin
                dump_ready = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk1);
        checks++;
        if ({host_wr_ready, busy, core_run, core_init, mem_we, dump_valid, dump_last, timeout} !== 8'b1000_0000) begin
            errors++; $display("FAIL reset_ctl: got %b expected 10000000",
                {host_wr_ready, busy, core_run, core_init, mem_we, dump_valid, dump_last, timeout});
        end
        checks++;
        if (run_cycles !== 16'd0 || dump_idx !== 5'd0 || dump_data !== 32'd0) begin
            errors++; $display("FAIL reset_regs: run_cycles %0d idx %0d data %0d expected 0", run_cycles, dump_idx, dump_data);
        end
        rst_n = 1'b1;
        @(negedge clk1);
        checks++;
        if (host_wr_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: ready %b busy %b expected 1 0", host_wr_ready, busy);
        end
    endtask

    task automatic test_addition();
        logic [31:0] exp_d [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        bit seen = 0;
        int bad = 0;
        set_add_prog();
        wr_log.delete();
        load_words(9, 1'b0, 1'b1, 1'b0);
        checks++;
        if (core_init !== 1'b1 || core_run !== 1'b0) begin
            errors++; $display("FAIL init_pulse: init %b run %b expected 1 0", core_init, core_run);
        end
        for (int i = 0; i < 9; i++) if (wr_log.size() != 9 || wr_log[i] != i || imem[i] !== prog[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL load_addr: %0d writes, %0d bad entries, expected 9 writes 0..8", wr_log.size(), bad);
        end
        @(negedge clk1);
        checks++;
        if (core_init !== 1'b0 || core_run !== 1'b1) begin
            errors++; $display("FAIL run_start: init %b run %b expected 0 1", core_init, core_run);
        end
        for (int c = 0; c < 200; c++) begin
            if (core_run && core_halted) begin seen = 1; break; end
            @(negedge clk1);
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL halt_wait: no halt within 200 cycles"); end
        @(negedge clk1);
        checks++;
        if (dump_valid !== 1'b0 || reg_rd_addr !== 5'd0) begin
            errors++; $display("FAIL dump_rd: valid %b rd_addr %0d expected 0 0", dump_valid, reg_rd_addr);
        end
        @(negedge clk1);
        checks++;
        if (dump_valid !== 1'b1) begin errors++; $display("FAIL dump_latency: valid %b expected 1", dump_valid); end
        collect(-1, 0);
        checks++;
        if (ncol != 6) begin errors++; $display("FAIL add_count: got %0d words expected 6", ncol); end
        for (int i = 0; i < ncol; i++) begin
            checks++;
            if (got_data[i] !== exp_d[i] || got_idx[i] !== 5'(i) || got_last[i] !== (i == 5)) begin
                errors++; $display("FAIL add_dump[%0d]: data %0d idx %0d last %b expected %0d %0d %b",
                    i, got_data[i], got_idx[i], got_last[i], exp_d[i], i, (i == 5));
            end
        end
        checks++;
        if (timeout !== 1'b0 || run_cycles !== 16'd10) begin
            errors++; $display("FAIL add_status: timeout %b run_cycles %0d expected 0 10", timeout, run_cycles);
        end
        @(negedge clk1);
        checks++;
        if (busy !== 1'b1 || dump_valid !== 1'b0) begin
            errors++; $display("FAIL done_state: busy %b valid %b expected 1 0", busy, dump_valid);
        end
        @(negedge clk1);
        checks++;
        if (busy !== 1'b0 || host_wr_ready !== 1'b1) begin
            errors++; $display("FAIL back_idle: busy %b ready %b expected 0 1", busy, host_wr_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_d [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        int bad = 0;
        set_add_prog();
        load_words(9, 1'b0, 1'b1, 1'b0);
        collect(2, 5);
        for (int i = 0; i < nheld; i++) if (held_data[i] !== 32'd20 || held_idx[i] !== 5'd2) bad++;
        checks++;
        if (nheld != 5 || bad != 0) begin
            errors++; $display("FAIL bp_hold: %0d stall samples, %0d changed, expected 5 samples of idx 2 data 20", nheld, bad);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) if (got_data[i] !== exp_d[i] || got_idx[i] !== 5'(i)) bad++;
        checks++;
        if (ncol != 6 || bad != 0) begin
            errors++; $display("FAIL bp_seq: %0d words, %0d wrong, expected 6 words 0..5", ncol, bad);
        end
        repeat (3) @(negedge clk1);
    endtask

    task automatic test_watchdog();
        logic [31:0] exp_d [6] = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd30, 32'd55};
        int bad = 0;
        prog[0] = 32'h00E73825;
        block_halt = 1'b1;
        load_words(1, 1'b0, 1'b1, 1'b0);
        collect(-1, 0);
        checks++;
        if (timeout !== 1'b1 || run_cycles !== 16'd50) begin
            errors++; $display("FAIL wd_status: timeout %b run_cycles %0d expected 1 50", timeout, run_cycles);
        end
        for (int i = 0; i < 6; i++) if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 5)) bad++;
        checks++;
        if (ncol != 6 || bad != 0) begin
            errors++; $display("FAIL wd_dump: %0d words, %0d wrong, expected 6 correct words", ncol, bad);
        end
        repeat (3) @(negedge clk1);
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL wd_sticky: timeout %b busy %b expected 1 0", timeout, busy);
        end
    endtask

    task automatic test_halt_at_timeout();
        prog[0] = 32'h00E73825;
        block_halt = 1'b1;
        inject_at = 50;
        load_words(1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (timeout !== 1'b0 || run_cycles !== 16'd0) begin
            errors++; $display("FAIL load_clear: timeout %b run_cycles %0d expected 0 0", timeout, run_cycles);
        end
        collect(-1, 0);
        checks++;
        if (timeout !== 1'b0 || run_cycles !== 16'd50 || ncol != 6 || got_last[5] !== 1'b1) begin
            errors++; $display("FAIL coincide: timeout %b run_cycles %0d words %0d expected 0 50 6",
                timeout, run_cycles, ncol);
        end
        inject_at = 0;
        block_halt = 1'b0;
        repeat (3) @(negedge clk1);
    endtask

    task automatic test_reset_mid_run();
        set_add_prog();
        block_halt = 1'b1;
        load_words(9, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk1);
        checks++;
        if (core_run !== 1'b1) begin errors++; $display("FAIL mid_run: core_run %b expected 1", core_run); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({core_run, core_init, busy, dump_valid, mem_we, host_wr_ready} !== 6'b000001 || run_cycles !== 16'd0) begin
            errors++; $display("FAIL async_reset: run/init/busy/valid/we/ready %b run_cycles %0d expected 000001 0",
                {core_run, core_init, busy, dump_valid, mem_we, host_wr_ready}, run_cycles);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        block_halt = 1'b0;
        @(negedge clk1);
        checks++;
        if (busy !== 1'b0 || host_wr_ready !== 1'b1 || core_run !== 1'b0) begin
            errors++; $display("FAIL post_reset: busy %b ready %b run %b expected 0 1 0", busy, host_wr_ready, core_run);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [6] = '{32'd0, 32'd3, 32'd4, 32'd7, 32'd30, 32'd55};
        int bad = 0;
        set_add_prog();
        load_words(9, 1'b0, 1'b1, 1'b0);
        collect(-1, 0);
        repeat (3) @(negedge clk1);
        checks++;
        if (busy !== 1'b0 || run_cycles !== 16'd10 || ncol != 6) begin
            errors++; $display("FAIL b2b_first: busy %b run_cycles %0d words %0d expected 0 10 6", busy, run_cycles, ncol);
        end
        prog[0] = 32'h20010003; prog[1] = 32'h20020004; prog[2] = 32'h00221820; prog[3] = 32'hFC000000;
        wr_log.delete();
        load_words(4, 1'b0, 1'b1, 1'b0);
        checks++;
        if (run_cycles !== 16'd0 || timeout !== 1'b0 || wr_log.size() != 4 || wr_log[0] != 0 || wr_log[3] != 3) begin
            errors++; $display("FAIL b2b_load: run_cycles %0d timeout %b writes %0d expected 0 0 4",
                run_cycles, timeout, wr_log.size());
        end
        collect(-1, 0);
        for (int i = 0; i < 6; i++) if (got_data[i] !== exp_d[i] || got_idx[i] !== 5'(i)) bad++;
        checks++;
        if (ncol != 6 || bad != 0) begin
            errors++; $display("FAIL b2b_dump: %0d words, %0d wrong, expected 0,3,4,7,30,55", ncol, bad);
        end
        checks++;
        if (run_cycles !== 16'd5 || timeout !== 1'b0) begin
            errors++; $display("FAIL b2b_status: run_cycles %0d timeout %b expected 5 0", run_cycles, timeout);
        end
        repeat (3) @(negedge clk1);
    endtask

    task automatic test_overflow();
        int bad = 0;
        for (int i = 0; i < 10; i++) prog[i] = 32'hA000_0000 + i;
        load_words(10, 1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 100 && ovf_busy; c++) @(negedge clk1);
        checks++;
        if (ovf_busy !== 1'b0) begin errors++; $display("FAIL ovf_idle: busy %b expected 0", ovf_busy); end
        for (int i = 0; i < 8; i++) if (ovf_log.size() != 8 || ovf_log[i] != i || ovf_mem[i] !== prog[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL ovf_writes: %0d writes, %0d bad, expected 8 writes to 0..7", ovf_log.size(), bad);
        end
        checks++;
        if (ovf_init_cnt != 1 || ovf_init_cyc != ovf_last_wr_cyc + 1) begin
            errors++; $display("FAIL ovf_init: %0d pulses at cycle %0d, expected 1 at cycle %0d",
                ovf_init_cnt, ovf_init_cyc, ovf_last_wr_cyc + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        host_wr_valid = 1'b0; host_wr_last = 1'b0; host_wr_data = '0;
        ovf_valid = 1'b0; dump_ready = 1'b0;
        for (int i = 0; i < 1024; i++) imem[i] = '0;
        for (int i = 0; i < 32; i++) regs[i] = '0;
        for (int i = 0; i < 8; i++) ovf_mem[i] = '0;
        test_reset();
        test_addition();
        test_backpressure();
        test_watchdog();
        test_halt_at_timeout();
        test_reset_mid_run();
        test_back_to_back();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded 10000 cycles");
        $fatal(1, "bench time limit reached");
    end
endmodule
